has_rr_scheduler: RTL and testbench

- Parametrised next-generation home-automation scanner.
- Visits N_CH binary sensor channels and one temperature slot in fixed round-robin order, so no channel is starved.
- Each visit updates that channel's registered actuator output; the temperature slot updates heater/cooler with hysteresis.
- Sits between the sensor front-end and the actuator drivers. The slot index also drives the status display.

---
 rtl/has_rr_scheduler_if.sv | 28 ++
 rtl/has_rr_scheduler.sv | 107 ++++++++++
 tb/tb_has_rr_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/has_rr_scheduler_if.sv
// rtl/has_rr_scheduler_if.sv - sensor/actuator bundle for the round-robin scanner
// Master drives sensor inputs and scan enable; slave (the scanner) drives actuators and display.
interface has_rr_scheduler_if #(
   parameter int N_CH = 4,
   parameter int TW   = 7
);
   localparam int SW = $clog2(N_CH + 1);

   logic            en;
   logic [N_CH-1:0] sens;
   logic [TW-1:0]   st;
   logic            alarm_clr;
   logic [N_CH-1:0] act;
   logic            heater;
   logic            cooler;
   logic [SW-1:0]   display;
   logic            scan_done;

   modport master (
      output en, sens, st, alarm_clr,
      input  act, heater, cooler, display, scan_done
   );

   modport slave (
      input  en, sens, st, alarm_clr,
      output act, heater, cooler, display, scan_done
   );
endinterface

// File: rtl/has_rr_scheduler.sv
// rtl/has_rr_scheduler.sv - round-robin sensor scanner with hysteretic heater/cooler slot
// Optional HAS_ALARM_LATCH_EN makes channel 0 a sticky alarm cleared by alarm_clr.
module has_rr_scheduler #(
   parameter int N_CH   = 4,
   parameter int TW     = 7,
   parameter int T_LOW  = 50,
   parameter int T_HIGH = 60,
   parameter int DWELL  = 1
) (
   input logic                clk,
   input logic                rst,
   has_rr_scheduler_if.slave  bus
);
   localparam int SW    = $clog2(N_CH + 1);
   localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int T_MID = (T_LOW + T_HIGH) / 2;

   localparam logic [TW-1:0] LO_W      = TW'(T_LOW);
   localparam logic [TW-1:0] HI_W      = TW'(T_HIGH);
   localparam logic [TW-1:0] MID_W     = TW'(T_MID);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
   localparam logic [SW-1:0] TEMP_SLOT = SW'(N_CH);

   logic [SW-1:0]   disp_q, disp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_CH-1:0] act_q, act_d;
   logic            heat_q, heat_d;
   logic            cool_q, cool_d;
   logic            done_q, done_d;
   logic            last;
`ifdef HAS_ALARM_LATCH_EN
   logic            alarm_set;
`endif

   always_comb begin
      disp_d = disp_q;
      cnt_d  = cnt_q;
      act_d  = act_q;
      heat_d = heat_q;
      cool_d = cool_q;
      done_d = 1'b0;
      last   = bus.en && (cnt_q == CNT_LAST) && (disp_q <= TEMP_SLOT);

      if (disp_q > TEMP_SLOT) begin
         disp_d = '0;
         cnt_d  = '0;
      end else if (bus.en) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            disp_d = (disp_q == TEMP_SLOT) ? '0 : disp_q + 1'b1;
            done_d = (disp_q == TEMP_SLOT);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (last) begin
         for (int k = 0; k < N_CH; k++) begin
            if (disp_q == SW'(k)) act_d[k] = bus.sens[k];
         end
         // Between the thresholds each drive only releases once st crosses the midpoint.
         if (disp_q == TEMP_SLOT) begin
            if (bus.st < LO_W) begin
               heat_d = 1'b1;
               cool_d = 1'b0;
            end else if (bus.st > HI_W) begin
               heat_d = 1'b0;
               cool_d = 1'b1;
            end else begin
               if (bus.st >= MID_W) heat_d = 1'b0;
               if (bus.st <= MID_W) cool_d = 1'b0;
            end
         end
      end

`ifdef HAS_ALARM_LATCH_EN
      alarm_set = last && (disp_q == '0) && bus.sens[0];
      if (alarm_set)          act_d[0] = 1'b1;
      else if (bus.alarm_clr) act_d[0] = 1'b0;
      else                    act_d[0] = act_q[0];
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_q <= '0;
         cnt_q  <= '0;
         act_q  <= '0;
         heat_q <= 1'b0;
         cool_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         disp_q <= disp_d;
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         heat_q <= heat_d;
         cool_q <= cool_d;
         done_q <= done_d;
      end
   end

   assign bus.act       = act_q;
   assign bus.heater    = heat_q;
   assign bus.cooler    = cool_q;
   assign bus.display   = disp_q;
   assign bus.scan_done = done_q;
endmodule

// File: tb/tb_has_rr_scheduler.sv
// tb/tb_has_rr_scheduler.sv - randomized and directed bench for has_rr_scheduler (DWELL 1 and 3)
// A position-in-round reference model predicts every output after each clock edge.
module tb_has_rr_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [3:0] sens = '0;
   logic [6:0] st = 7'd55;
   logic       alarm_clr = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   has_rr_scheduler_if #(.N_CH(4), .TW(7)) ifa ();
   has_rr_scheduler_if #(.N_CH(4), .TW(7)) ifb ();

   assign ifa.en = en;  assign ifa.sens = sens;  assign ifa.st = st;  assign ifa.alarm_clr = alarm_clr;
   assign ifb.en = en;  assign ifb.sens = sens;  assign ifb.st = st;  assign ifb.alarm_clr = alarm_clr;

   has_rr_scheduler #(.N_CH(4), .TW(7), .T_LOW(50), .T_HIGH(60), .DWELL(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa));
   has_rr_scheduler #(.N_CH(4), .TW(7), .T_LOW(50), .T_HIGH(60), .DWELL(3)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb));

   always #5 clk = ~clk;

   int         dw [2] = '{1, 3};
   int         pos [2];
   logic [3:0] m_act [2];
   logic       m_heat [2];
   logic       m_cool [2];
   logic       m_done [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         pos[d] = 0; m_act[d] = '0; m_heat[d] = 1'b0; m_cool[d] = 1'b0; m_done[d] = 1'b0;
      end
   endtask

   task automatic model_edge();
      int  slot;
      bit  fin;
      bit  set0;
      for (int d = 0; d < 2; d++) begin
         m_done[d] = 1'b0;
         set0 = 1'b0;
         if (en) begin
            slot = pos[d] / dw[d];
            fin  = (pos[d] % dw[d]) == dw[d] - 1;
            if (fin && slot < 4) begin
`ifdef HAS_ALARM_LATCH_EN
               if (slot == 0) begin
                  set0 = sens[0];
                  if (sens[0]) m_act[d][0] = 1'b1;
               end else m_act[d][slot] = sens[slot];
`else
               m_act[d][slot] = sens[slot];
`endif
            end
            if (fin && slot == 4) begin
               if (int'(st) < 50) begin
                  m_heat[d] = 1'b1; m_cool[d] = 1'b0;
               end else if (int'(st) > 60) begin
                  m_heat[d] = 1'b0; m_cool[d] = 1'b1;
               end else begin
                  if (int'(st) >= 55) m_heat[d] = 1'b0;
                  if (int'(st) <= 55) m_cool[d] = 1'b0;
               end
               m_done[d] = 1'b1;
            end
            pos[d] = (pos[d] + 1) % (5 * dw[d]);
         end
`ifdef HAS_ALARM_LATCH_EN
         if (alarm_clr && !set0) m_act[d][0] = 1'b0;
`endif
      end
   endtask

   task automatic compare();
      check("a_disp", 32'(ifa.display), 32'(pos[0] / dw[0]));
      check("a_act", 32'(ifa.act), 32'(m_act[0]));
      check("a_heat", 32'(ifa.heater), 32'(m_heat[0]));
      check("a_cool", 32'(ifa.cooler), 32'(m_cool[0]));
      check("a_done", 32'(ifa.scan_done), 32'(m_done[0]));
      check("a_excl", 32'(ifa.heater & ifa.cooler), 32'd0);
      check("b_disp", 32'(ifb.display), 32'(pos[1] / dw[1]));
      check("b_act", 32'(ifb.act), 32'(m_act[1]));
      check("b_heat", 32'(ifb.heater), 32'(m_heat[1]));
      check("b_cool", 32'(ifb.cooler), 32'(m_cool[1]));
      check("b_done", 32'(ifb.scan_done), 32'(m_done[1]));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   // Called just after a rising edge; reset lands mid-cycle and is checked before the next edge.
   task automatic do_reset();
      #4;
      rst = 1'b0;
      #1;
      check("rst_a_out", 32'({ifa.act, ifa.heater, ifa.cooler, ifa.scan_done}), 32'd0);
      check("rst_a_disp", 32'(ifa.display), 32'd0);
      check("rst_b_out", 32'({ifb.act, ifb.heater, ifb.cooler, ifb.scan_done}), 32'd0);
      check("rst_b_disp", 32'(ifb.display), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic run_to_pos(input int d, input int p);
      for (int i = 0; i < 40 && pos[d] != p; i++) tick();
   endtask

   int hyst_st [6] = '{45, 52, 55, 61, 58, 55};
   int hyst_h  [6] = '{1, 1, 0, 0, 0, 0};
   int hyst_c  [6] = '{0, 0, 0, 1, 1, 0};
   logic [3:0] s_hold;

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // round-robin with constant sensors
      en = 1'b1; sens = 4'b1010; st = 7'd55;
      repeat (4) tick();
      check("rr_disp4", 32'(ifa.display), 32'd4);
      check("rr_act", 32'(ifa.act), 32'b1010);
      tick();
      check("rr_wrap", 32'(ifa.display), 32'd0);
      check("rr_done", 32'(ifa.scan_done), 32'd1);
      repeat (5) tick();

      // hysteresis
      for (int i = 0; i < 6; i++) begin
         st = 7'(hyst_st[i]);
         repeat (15) tick();
         check("hyst_heat", 32'(ifa.heater), 32'(hyst_h[i]));
         check("hyst_cool", 32'(ifa.cooler), 32'(hyst_c[i]));
      end

      // freeze at display 3
      run_to_pos(0, 3);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sens = 4'($urandom); st = 7'($urandom);
         tick();
      end
      check("frz_disp", 32'(ifa.display), 32'd3);
      en = 1'b1; s_hold = 4'($urandom); sens = s_hold;
      tick();
      check("frz_ch3", 32'(ifa.act[3]), 32'(s_hold[3]));

      // dwell window on the DWELL=3 instance
      do_reset();
      en = 1'b1; sens = '0; st = 7'd55;
      run_to_pos(1, 3);
      sens = 4'b0010; tick(); sens = '0; tick(); tick();
      check("dwell_first", 32'(ifb.act[1]), 32'd0);
      run_to_pos(1, 5);
      sens = 4'b0010; tick(); sens = '0;
      check("dwell_last", 32'(ifb.act[1]), 32'd1);

      // mid-slot reset with live outputs
      do_reset();
      en = 1'b1; sens = 4'b0011; st = 7'd45;
      repeat (5) tick();
      run_to_pos(0, 2);
      check("pre_rst_act", 32'(ifa.act), 32'b0011);
      check("pre_rst_heat", 32'(ifa.heater), 32'd1);
      do_reset();
      tick();
      check("restart", 32'(ifa.display), 32'd1);

      // alarm channel behaviour
      do_reset();
      en = 1'b1; st = 7'd55; sens = 4'b0001;
      repeat (5) tick();
      sens = '0;
      repeat (15) tick();
`ifdef HAS_ALARM_LATCH_EN
      check("alarm_hold", 32'(ifa.act[0]), 32'd1);
`else
      check("alarm_hold", 32'(ifa.act[0]), 32'd0);
`endif
      alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
      check("alarm_clr", 32'(ifa.act[0]), 32'd0);
      run_to_pos(0, 0);
      sens = 4'b0001; alarm_clr = 1'b1; tick();
      sens = '0; alarm_clr = 1'b0;
      check("alarm_setwin", 32'(ifa.act[0]), 32'd1);

      // randomized soak
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         sens = 4'($urandom);
         st = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(40, 70));
         alarm_clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 299) == 0) do_reset();
         else tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
